// File: rtl/vec_apu_responder_if.sv
// Core-side APU offload bus: request with instruction/operands toward the
// accelerator, grant and single-cycle result strobe back to the core.
interface vec_apu_responder_if;
    logic        apu_req;
    logic [31:0] apu_operands_0;
    logic [31:0] apu_operands_1;
    logic [31:0] apu_operands_2;
    logic        apu_gnt;
    logic        apu_rvalid;
    logic [31:0] apu_result;
    logic [1:0]  apu_flags;

    modport master (
        output apu_req,
        output apu_operands_0,
        output apu_operands_1,
        output apu_operands_2,
        input  apu_gnt,
        input  apu_rvalid,
        input  apu_result,
        input  apu_flags
    );

    modport slave (
        input  apu_req,
        input  apu_operands_0,
        input  apu_operands_1,
        input  apu_operands_2,
        output apu_gnt,
        output apu_rvalid,
        output apu_result,
        output apu_flags
    );
endinterface

// File: rtl/vec_apu_responder.sv
// Accelerator-side APU responder: screens the major opcode, dispatches legal
// vector instructions to the decoder and returns one result per granted request.
module vec_apu_responder #(
    parameter int VL_W           = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 n_reset,
    vec_apu_responder_if.slave   apu,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [31:0]          instr,
    output logic [31:0]          scalar_rs1,
    output logic [31:0]          scalar_rs2,
    input  logic                 exec_done,
    input  logic                 result_src,
    input  logic [VL_W-1:0]      vl,
    input  logic [31:0]          vs2_elem0
);

    localparam logic [6:0] V_MAJOR_LOAD_FP  = 7'b000_0111;
    localparam logic [6:0] V_MAJOR_STORE_FP = 7'b010_0111;
    localparam logic [6:0] V_MAJOR_OP_V     = 7'b101_0111;

    localparam logic APU_RESULT_SRC_VL    = 1'b0;
    localparam logic APU_RESULT_SRC_VS2_0 = 1'b1;

    localparam logic [1:0] FLAGS_OK      = 2'b00;
    localparam logic [1:0] FLAGS_ILLEGAL = 2'b01;
    localparam logic [1:0] FLAGS_TIMEOUT = 2'b10;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DISPATCH = 2'd1;
    localparam logic [1:0] ST_WAIT     = 2'd2;
    localparam logic [1:0] ST_RESP     = 2'd3;

    localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // VL is zero-extended; vs2 element 0 arrives already sign-extended.
    function automatic logic [31:0] fmt_result(
        input logic                src,
        input logic [VL_W-1:0]     vl_val,
        input logic signed [31:0]  elem0
    );
        logic [31:0] res;
        res = 32'(vl_val);
        if (src == APU_RESULT_SRC_VS2_0) begin
            res = elem0;
        end
        return res;
    endfunction

    function automatic logic is_legal_major(input logic [6:0] major);
        return (major == V_MAJOR_LOAD_FP) ||
               (major == V_MAJOR_STORE_FP) ||
               (major == V_MAJOR_OP_V);
    endfunction

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [CNT_W-1:0]   wait_cnt;
    logic               op_legal_p0;
    logic               grant_p0;
    logic               wait_last_p0;
    logic signed [31:0] elem0_p0;
    logic [31:0]        done_res_p0;

    assign op_legal_p0  = is_legal_major(apu.apu_operands_0[6:0]);
    assign grant_p0     = (state == ST_IDLE) && apu.apu_req;
    assign wait_last_p0 = (wait_cnt == CNT_LAST);
    assign elem0_p0     = signed'(vs2_elem0);
    assign done_res_p0  = fmt_result(result_src, vl, elem0_p0);

    assign apu.apu_gnt    = grant_p0;
    assign apu.apu_rvalid = (state == ST_RESP);
    assign instr_valid    = (state == ST_DISPATCH);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (apu.apu_req) begin
                    state_nxt = op_legal_p0 ? ST_DISPATCH : ST_RESP;
                end
            end
            ST_DISPATCH: begin
                if (instr_ready) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (exec_done || wait_last_p0) begin
                    state_nxt = ST_RESP;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Grant / completion stage: operands captured on grant, result on completion.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state          <= ST_IDLE;
            wait_cnt       <= '0;
            instr          <= '0;
            scalar_rs1     <= '0;
            scalar_rs2     <= '0;
            apu.apu_result <= '0;
            apu.apu_flags  <= FLAGS_OK;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (grant_p0) begin
                        instr      <= apu.apu_operands_0;
                        scalar_rs1 <= apu.apu_operands_1;
                        scalar_rs2 <= apu.apu_operands_2;
                        if (!op_legal_p0) begin
                            apu.apu_result <= '0;
                            apu.apu_flags  <= FLAGS_ILLEGAL;
                        end
                    end
                end
                ST_DISPATCH: begin
                    wait_cnt <= '0;
                end
                ST_WAIT: begin
                    // A completion on the last count cycle still wins over the timeout.
                    if (exec_done) begin
                        apu.apu_result <= done_res_p0;
                        apu.apu_flags  <= FLAGS_OK;
                    end else if (wait_last_p0) begin
                        apu.apu_result <= '1;
                        apu.apu_flags  <= FLAGS_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    a_rvalid_single: assert property (
        @(posedge clk) disable iff (!n_reset) apu.apu_rvalid |=> !apu.apu_rvalid
    );

    a_gnt_only_idle: assert property (
        @(posedge clk) disable iff (!n_reset) apu.apu_gnt |-> (state == ST_IDLE)
    );

endmodule

// File: tb/tb_vec_apu_responder.sv
// Randomized scoreboard bench for vec_apu_responder with a transaction-level model.
module tb_vec_apu_responder;

    localparam int   T       = 4;
    localparam logic SRC_VL  = 1'b0;
    localparam logic SRC_VS2 = 1'b1;

    typedef struct {
        logic [31:0] res;
        logic [1:0]  flg;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        n_reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] scalar_rs1;
    logic [31:0] scalar_rs2;
    logic        exec_done;
    logic        result_src;
    logic [7:0]  vl;
    logic [31:0] vs2_elem0;

    vec_apu_responder_if apu_bus ();

    vec_apu_responder #(
        .VL_W           (8),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .apu         (apu_bus),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .scalar_rs1  (scalar_rs1),
        .scalar_rs2  (scalar_rs2),
        .exec_done   (exec_done),
        .result_src  (result_src),
        .vl          (vl),
        .vs2_elem0   (vs2_elem0)
    );

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         n_rvalid = 0;
    int         cyc = 0;
    logic [6:0] legal_majors [3] = '{7'h07, 7'h27, 7'h57};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] major);
        for (int i = 0; i < 3; i++) begin
            if (legal_majors[i] == major) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Monitor: every result strobe must match the oldest outstanding expectation.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (n_reset === 1'b1 && apu_bus.apu_rvalid === 1'b1) begin
            n_rvalid++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rvalid: got rvalid=1 at cycle %0d, required none", cyc);
            end else begin
                e = sb.pop_front();
                chk("result", apu_bus.apu_result, e.res);
                chk("flags", 32'(apu_bus.apu_flags), 32'(e.flg));
                chk("rvalid_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // k = WAIT-cycle index of the exec_done pulse; k >= T means no pulse.
    task automatic run_txn(input logic [31:0] op0, input logic [31:0] rs1, input logic [31:0] rs2,
                           input int rd, input int k, input logic src, input logic [7:0] v,
                           input logic [31:0] e0, input bit dpulse);
        exp_t e;
        int   g;
        int   guard;
        int   n0;
        bit   legal;
        legal = is_legal(op0[6:0]);
        n0    = n_rvalid;
        @(negedge clk);
        apu_bus.apu_req        = 1'b1;
        apu_bus.apu_operands_0 = op0;
        apu_bus.apu_operands_1 = rs1;
        apu_bus.apu_operands_2 = rs2;
        #1;
        guard = 0;
        while (apu_bus.apu_gnt !== 1'b1 && guard < 20) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (apu_bus.apu_gnt !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL grant_wait: got no grant in 20 cycles, required grant");
            apu_bus.apu_req = 1'b0;
            return;
        end
        g = cyc;
        if (!legal) begin
            e.res = 32'h0;
            e.flg = 2'b01;
            e.cyc = g + 1;
        end else if (k < T) begin
            e.res = (src == SRC_VS2) ? e0 : {24'h0, v};
            e.flg = 2'b00;
            e.cyc = g + 3 + rd + k;
        end else begin
            e.res = 32'hFFFF_FFFF;
            e.flg = 2'b10;
            e.cyc = g + 2 + rd + T;
        end
        sb.push_back(e);

        @(negedge clk);
        apu_bus.apu_req        = 1'b0;
        apu_bus.apu_operands_0 = $urandom;
        apu_bus.apu_operands_1 = $urandom;
        apu_bus.apu_operands_2 = $urandom;
        if (!legal) begin
            chk("illegal_no_dispatch", 32'(instr_valid), 32'd0);
        end else begin
            for (int i = 0; i <= rd; i++) begin
                if (i > 0) @(negedge clk);
                chk("instr_valid", 32'(instr_valid), 32'd1);
                chk("instr_hold", instr, op0);
                if (i == 0) begin
                    chk("scalar_rs1", scalar_rs1, rs1);
                    chk("scalar_rs2", scalar_rs2, rs2);
                end
                instr_ready = (i == rd);
                exec_done   = dpulse && (i == rd || i == 0);
                result_src  = 1'($urandom_range(0, 1));
                vl          = 8'($urandom);
                vs2_elem0   = $urandom;
            end
            for (int j = 0; j <= k && j < T; j++) begin
                @(negedge clk);
                instr_ready = 1'b0;
                exec_done   = (j == k);
                if (j == k) begin
                    result_src = src;
                    vl         = v;
                    vs2_elem0  = e0;
                end
            end
            @(negedge clk);
            instr_ready = 1'b0;
            exec_done   = 1'b0;
        end
        guard = 0;
        while (sb.size() != 0 && guard < 4 * T + 40) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rvalid_wait: got no rvalid within %0d cycles, required one", guard);
            sb.delete();
        end
        chk("one_response", 32'(n_rvalid - n0), 32'd1);
    endtask

    initial begin
        int         n0;
        int         r;
        logic [31:0] op;
        n_reset                = 1'b0;
        apu_bus.apu_req        = 1'b0;
        apu_bus.apu_operands_0 = '0;
        apu_bus.apu_operands_1 = '0;
        apu_bus.apu_operands_2 = '0;
        instr_ready            = 1'b0;
        exec_done              = 1'b0;
        result_src             = 1'b0;
        vl                     = '0;
        vs2_elem0              = '0;
        repeat (3) @(negedge clk);
        chk("rst_rvalid", 32'(apu_bus.apu_rvalid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_result", apu_bus.apu_result, 32'd0);
        chk("rst_flags", 32'(apu_bus.apu_flags), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_gnt", 32'(apu_bus.apu_gnt), 32'd0);
        n_reset = 1'b1;

        // vsetvli, vmv.x.s, illegal, backpressure with ignored DISPATCH pulse
        run_txn(32'h0C05_72D7, 32'h0000_0020, 32'h0, 0, 2, SRC_VL, 8'd16, 32'h0, 1'b0);
        run_txn(32'h4220_2557, 32'hCAFE_0001, 32'h1234_5678, 0, 1, SRC_VS2, 8'd3, 32'hFFFF_FF80, 1'b0);
        run_txn(32'h0000_0033, 32'h1111_1111, 32'h2222_2222, 0, 0, SRC_VL, 8'd0, 32'h0, 1'b0);
        run_txn(32'h0200_7007, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 5, 2, SRC_VS2, 8'd9, 32'h0000_0042, 1'b1);
        // exec_done on the final count cycle, then a true timeout
        run_txn(32'h0C05_72D7, 32'h1, 32'h2, 0, T - 1, SRC_VS2, 8'd1, 32'h1234_5678, 1'b0);
        run_txn(32'h0200_7027, 32'h3, 32'h4, 0, T, SRC_VL, 8'd1, 32'h0, 1'b0);

        // reset while in WAIT
        @(negedge clk);
        apu_bus.apu_req        = 1'b1;
        apu_bus.apu_operands_0 = 32'h0C05_72D7;
        apu_bus.apu_operands_1 = 32'h7777_7777;
        apu_bus.apu_operands_2 = 32'h8888_8888;
        #1;
        chk("gnt_pre_reset", 32'(apu_bus.apu_gnt), 32'd1);
        @(negedge clk);
        apu_bus.apu_req = 1'b0;
        instr_ready     = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        @(negedge clk);
        #2;
        n_reset = 1'b0;
        #1;
        chk("rst_wait_rvalid", 32'(apu_bus.apu_rvalid), 32'd0);
        chk("rst_wait_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_wait_result", apu_bus.apu_result, 32'd0);
        chk("rst_wait_flags", 32'(apu_bus.apu_flags), 32'd0);
        chk("rst_wait_instr", instr, 32'd0);
        chk("rst_wait_rs1", scalar_rs1, 32'd0);
        chk("rst_wait_rs2", scalar_rs2, 32'd0);
        @(negedge clk);
        @(negedge clk);
        n_reset = 1'b1;
        n0 = n_rvalid;
        repeat (4) @(negedge clk);
        chk("no_stale_rvalid", 32'(n_rvalid - n0), 32'd0);

        // back-to-back after reset, then randomized traffic
        run_txn(32'h0000_0013, 32'h5, 32'h6, 0, 0, SRC_VL, 8'd0, 32'h0, 1'b0);
        run_txn(32'h0C05_72D7, 32'h9, 32'hA, 1, 0, SRC_VL, 8'd200, 32'h0, 1'b0);
        for (int n = 0; n < 40; n++) begin
            r  = int'($urandom_range(0, 3));
            op = $urandom;
            if (r < 3) op[6:0] = legal_majors[r];
            run_txn(op, $urandom, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, T + 1)),
                    1'($urandom_range(0, 1)), 8'($urandom), $urandom, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500000 ns, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
